// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM with valid/ready requests, byte enables, range checking and a
// post-reset clear sweep. Define PARITY_EN to store even parity per byte and report parity_err.
module ram_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
`ifdef PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PARITY_EN
  localparam int MEM_W = DATA_W + NB;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [MEM_W-1:0] mem [DEPTH];
  logic [MEM_W-1:0] rd_word;
  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [MEM_W-1:0] w;
    w = '0;
    w[DATA_W-1:0] = d;
`ifdef PARITY_EN
    for (int i = 0; i < NB; i++) w[DATA_W+i] = ^d[8*i +: 8];
`endif
    return w;
  endfunction

  localparam logic [MEM_W-1:0] INIT_WORD = encode(INIT_VAL);

  assign accept   = req_valid && req_ready;
  // Compare at full address width so out-of-range requests never alias onto a truncated index.
  assign in_range = (req_addr <= ADDR_W'(DEPTH - 1));
  assign idx      = req_addr[IDX_W-1:0];
  assign rd_word  = mem[idx];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) cnt <= cnt + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && cnt == IDX_W'(DEPTH - 1)) state_nxt = S_IDLE;
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    init_done = (state == S_IDLE);
  end

  // NOTE: the array has no reset; the clear sweep initialises it, keeping it mappable to RAM macros.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= INIT_WORD;
    end else if (accept && req_we && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef PARITY_EN
          mem[idx][DATA_W+i] <= ^req_wdata[8*i +: 8];
`endif
        end
      end
    end
  end

`ifdef PARITY_EN
  logic par_mismatch;
  always_comb begin
    par_mismatch = 1'b0;
    for (int i = 0; i < NB; i++)
      par_mismatch = par_mismatch | ((^rd_word[8*i +: 8]) ^ rd_word[DATA_W+i]);
  end
`endif

  // Response fields only update on acceptance and otherwise hold their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err   <= !in_range;
        rsp_rdata <= (!req_we && in_range) ? rd_word[DATA_W-1:0] : '0;
`ifdef PARITY_EN
        parity_err <= !req_we && in_range && par_mismatch;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: stimulus pushes expected responses, a negedge monitor pops and
// compares them, including the response cycle. Parity checks are built when PARITY_EN is defined.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;
  logic        perr;

  ram_ctrl #(.DATA_W(16), .DEPTH(256), .ADDR_W(16), .INIT_VAL(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
`ifdef PARITY_EN
    ,
    .parity_err(perr)
`endif
  );

`ifndef PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic        perr;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every response must match the head of the queue on its due cycle.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q.size() == 0) begin
        check("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(e.due));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
`ifdef PARITY_EN
        check("parity_err", 32'(perr), 32'(e.perr));
`endif
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      check("rsp_valid_missing", 32'(rsp_valid), 32'd1);
      void'(q.pop_front());
    end
  end

  // Called at posedge+1; presents one request for exactly one accept edge.
  task automatic send(input logic we, input logic [15:0] addr, input logic [1:0] be,
                      input logic [15:0] wd, input logic [15:0] er, input logic ee,
                      input logic ep);
    exp_t x;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    x.rdata = er;
    x.err   = ee;
    x.perr  = ep;
    x.due   = cyc + 1;
    q.push_back(x);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {27'd0, req_ready, rsp_valid, |rsp_rdata, rsp_err, init_done}, 32'd0);
`ifdef PARITY_EN
    check({name, "_parity_err"}, 32'(perr), 32'd0);
`endif
  endtask

  // Called right after reset release at posedge+1; counts cycles until req_ready.
  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(n), 32'd256);
    check({name, "_init_done"}, 32'(init_done), 32'd1);
  endtask

`ifdef PARITY_EN
  task automatic flip_bit(input int addr, input int b);
    dut.mem[addr][b] = ~dut.mem[addr][b];
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    // Requests held during the sweep must be ignored entirely.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0010;
    req_be    = 2'b11;
    req_wdata = 16'hDEAD;
    #1;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sweep("sweep1_cycles");
    req_valid = 1'b0;
    req_we    = 1'b0;

    // 1: cleared contents, including the address targeted during the sweep
    send(1'b0, 16'h0000, 2'b00, 16'h0, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h007F, 2'b00, 16'h0, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h00FF, 2'b00, 16'h0, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h0010, 2'b00, 16'h0, 16'h0000, 1'b0, 1'b0);

    // 2: back-to-back write then read
    send(1'b1, 16'h0010, 2'b11, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h0010, 2'b00, 16'h0,    16'hBEEF, 1'b0, 1'b0);

    // 3: byte enables
    send(1'b1, 16'h0020, 2'b11, 16'h1234, 16'h0000, 1'b0, 1'b0);
    send(1'b1, 16'h0020, 2'b10, 16'hABCD, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h0020, 2'b00, 16'h0,    16'hAB34, 1'b0, 1'b0);
    send(1'b1, 16'h0020, 2'b00, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h0020, 2'b00, 16'h0,    16'hAB34, 1'b0, 1'b0);
    send(1'b1, 16'h0020, 2'b01, 16'h5566, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h0020, 2'b00, 16'h0,    16'hAB66, 1'b0, 1'b0);

    // 4: out-of-range accesses error out and must not alias onto low addresses
    send(1'b0, 16'h0100, 2'b00, 16'h0,    16'h0000, 1'b1, 1'b0);
    send(1'b1, 16'hFFFF, 2'b11, 16'h5555, 16'h0000, 1'b1, 1'b0);
    send(1'b1, 16'h0100, 2'b11, 16'h7777, 16'h0000, 1'b1, 1'b0);
    send(1'b0, 16'h00FF, 2'b00, 16'h0,    16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h0000, 2'b00, 16'h0,    16'h0000, 1'b0, 1'b0);

`ifdef PARITY_EN
    // 6: parity error injection
    send(1'b1, 16'h0005, 2'b11, 16'h00FF, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h0005, 2'b00, 16'h0,    16'h00FF, 1'b0, 1'b0);
    flip_bit(5, 3);
    send(1'b0, 16'h0005, 2'b00, 16'h0,    16'h00F7, 1'b0, 1'b1);
    send(1'b0, 16'h0010, 2'b00, 16'h0,    16'hBEEF, 1'b0, 1'b0);
`endif

    // 5: reset mid-sweep, then reset with a response pending
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_idle");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("mid_sweep_not_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_sweep");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sweep("sweep2_cycles");

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0010;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check_reset_outputs("reset_pending_rsp");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sweep("sweep3_cycles");

    send(1'b0, 16'h0010, 2'b00, 16'h0, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 16'h0020, 2'b00, 16'h0, 16'h0000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
